koopa_sprite_fetch: RTL and testbench

KOOPA_SPRITE_FETCH -- requirements
Module: koopa_sprite_fetch

---
 rtl/koopa_sprite_fetch.sv | 198 +++++++++++++++++++
 tb/tb_koopa_sprite_fetch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/koopa_sprite_fetch.sv
// koopa_sprite_fetch: sprite-sheet pixel fetcher for the Koopa walk animation.
// Each pixel request goes through a hit test against the sprite box. A hit
// becomes a sprite-sheet ROM address. The returned RGB444 word is then turned
// into a pixel plus an opaque flag. The pipeline accepts one request per cycle.
// Optional feature: define KOOPA_SPRITE_FLIP_EN to enable horizontal mirroring
// driven by the facing_left value captured at frame_start.
module koopa_sprite_fetch #(
  parameter int          SPR_W           = 23,
  parameter int          SPR_H           = 30,
  parameter int          SHEET_W_LOG2    = 7,
  parameter logic [11:0] TRANSPARENT_KEY = 12'hF0F
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              anim_row,
  input  logic [5:0]              anim_col,
  input  logic                    frame_start,
  input  logic                    pix_valid,
  input  logic [9:0]              hcount,
  input  logic [9:0]              vcount,
  input  logic [9:0]              sprite_x,
  input  logic [9:0]              sprite_y,
  input  logic                    facing_left,
  output logic [SHEET_W_LOG2+6:0] rom_addr,
  input  logic [11:0]             rom_data,
  output logic [11:0]             pix_out,
  output logic                    pix_opaque,
  output logic                    pix_out_valid
);

  localparam int AW = SHEET_W_LOG2 + 7;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } state_e;

  // Sheet address at full width, then truncated to the ROM address width.
  function automatic logic [AW-1:0] sheet_addr(input logic [5:0] row,
                                               input logic [5:0] col,
                                               input logic [9:0] dy,
                                               input logic [9:0] dx);
    logic [31:0] full;
    full = ((32'(row) + 32'(dy)) << SHEET_W_LOG2) + 32'(col) + 32'(dx);
    return full[AW-1:0];
  endfunction

  state_e          state_q, state_d;
  logic            rst_ok_q;
  logic            accept;
  logic            fs_go;

  logic [5:0]      row_sh_q;
  logic [5:0]      col_sh_q;
  logic            mirror;

  logic [10:0]     hx_ext, vy_ext, sx_ext, sy_ext, x_end, y_end;
  logic            hit_c;
  logic [9:0]      dx_raw, dx_c, dy_c;

  logic            vld_p0_q;
  logic            hit_p0_q;
  logic            run_p0_q;
  logic [9:0]      dx_p0_q, dy_p0_q;
  logic [5:0]      row_p0_q, col_p0_q;

  logic            vld_p1_q;
  logic            draw_p1_q;
  logic [AW-1:0]   rom_addr_q;

  logic            opaque_d;
  logic [11:0]     pix_d;
  logic            opaque_q;
  logic [11:0]     pix_q;
  logic            out_vld_q;

  // Reset release is retimed to the clock; nothing is accepted until this is set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_ok_q <= 1'b0;
    else        rst_ok_q <= 1'b1;
  end

  assign accept = pix_valid & rst_ok_q;
  assign fs_go  = frame_start & rst_ok_q;

  // State register for the frame-sync FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= WAIT_FRAME;
    else        state_q <= state_d;
  end

  // Next state: the first frame_start arms RUN, and RUN is left only by reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FRAME: if (fs_go) state_d = RUN;
      RUN:        state_d = RUN;
      default:    state_d = WAIT_FRAME;
    endcase
  end

  // Shadow copy of the animation frame origin, refreshed at each vertical blank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_sh_q <= '0;
      col_sh_q <= '0;
    end else if (fs_go) begin
      row_sh_q <= anim_row;
      col_sh_q <= anim_col;
    end
  end

`ifdef KOOPA_SPRITE_FLIP_EN
  logic face_sh_q;

  // Facing direction is captured together with the frame origin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     face_sh_q <= 1'b0;
    else if (fs_go) face_sh_q <= facing_left;
  end

  assign mirror = face_sh_q;
`else
  logic unused_facing;
  assign unused_facing = facing_left;
  assign mirror        = 1'b0;
`endif

  // The hit test is done at 11 bits, so a sprite near the right/bottom edge never wraps.
  always_comb begin
    hx_ext = {1'b0, hcount};
    vy_ext = {1'b0, vcount};
    sx_ext = {1'b0, sprite_x};
    sy_ext = {1'b0, sprite_y};
    x_end  = sx_ext + 11'(SPR_W);
    y_end  = sy_ext + 11'(SPR_H);
    hit_c  = (hx_ext >= sx_ext) && (hx_ext < x_end) &&
             (vy_ext >= sy_ext) && (vy_ext < y_end);
    dx_raw = hcount - sprite_x;
    dy_c   = vcount - sprite_y;
    dx_c   = mirror ? (10'(SPR_W - 1) - dx_raw) : dx_raw;
  end

  // ---- stage p0: request sampled with the shadow values in force this cycle ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p0_q <= 1'b0;
    else        vld_p0_q <= accept;
  end

  // Request payload; it is qualified by vld_p0_q, so it needs no reset.
  always_ff @(posedge clk) begin
    hit_p0_q <= hit_c;
    run_p0_q <= (state_q == RUN);
    dx_p0_q  <= dx_c;
    dy_p0_q  <= dy_c;
    row_p0_q <= row_sh_q;
    col_p0_q <= col_sh_q;
  end

  // ---- stage p1: ROM address issued; it holds when no valid hit arrives ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1_q   <= 1'b0;
      draw_p1_q  <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      vld_p1_q  <= vld_p0_q;
      draw_p1_q <= vld_p0_q & hit_p0_q & run_p0_q;
      if (vld_p0_q && hit_p0_q)
        rom_addr_q <= sheet_addr(row_p0_q, col_p0_q, dy_p0_q, dx_p0_q);
    end
  end

  // The colour key and misses both force a blank, non-drawable pixel.
  always_comb begin
    opaque_d = vld_p1_q & draw_p1_q & (rom_data != TRANSPARENT_KEY);
    pix_d    = opaque_d ? rom_data : 12'h000;
  end

  // ---- stage p2: ROM data consumed, pixel outputs registered ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vld_q <= 1'b0;
      opaque_q  <= 1'b0;
      pix_q     <= 12'h000;
    end else begin
      out_vld_q <= vld_p1_q;
      opaque_q  <= opaque_d;
      pix_q     <= pix_d;
    end
  end

  assign rom_addr      = rom_addr_q;
  assign pix_out       = pix_q;
  assign pix_opaque    = opaque_q;
  assign pix_out_valid = out_vld_q;

endmodule

// File: tb/tb_koopa_sprite_fetch.sv
// Directed bench for koopa_sprite_fetch; the sprite sits at (100,50) throughout.
module tb_koopa_sprite_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  anim_row, anim_col;
  logic        frame_start, pix_valid, facing_left;
  logic [9:0]  hcount, vcount, sprite_x, sprite_y;
  logic [13:0] rom_addr;
  logic [11:0] rom_data, pix_out;
  logic        pix_opaque, pix_out_valid;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef KOOPA_SPRITE_FLIP_EN
  localparam logic [13:0] FLIP_ADDR = 14'd3885;
`else
  localparam logic [13:0] FLIP_ADDR = 14'd3863;
`endif

  always #5 clk = ~clk;

  koopa_sprite_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .anim_row     (anim_row),
    .anim_col     (anim_col),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .hcount       (hcount),
    .vcount       (vcount),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .facing_left  (facing_left),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .pix_out      (pix_out),
    .pix_opaque   (pix_opaque),
    .pix_out_valid(pix_out_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [5:0] row, input logic [5:0] col, input logic face);
    anim_row    = row;
    anim_col    = col;
    facing_left = face;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
  endtask

  // One isolated request: the address is checked after stage p1, and the pixel after stage p2.
  task automatic do_req(input string tag, input logic [9:0] h, input logic [9:0] v,
                        input logic [11:0] rd, input logic [13:0] exp_addr,
                        input bit exp_opq);
    hcount    = h;
    vcount    = v;
    pix_valid = 1'b1;
    tick;
    pix_valid = 1'b0;
    tick;
    check({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
    rom_data = rd;
    tick;
    check({tag, "_vld"}, 32'(pix_out_valid), 32'd1);
    check({tag, "_opq"}, 32'(pix_opaque), 32'(exp_opq));
    check({tag, "_pix"}, 32'(pix_out), exp_opq ? 32'(rd) : 32'd0);
  endtask

  initial begin
    reset       = 1'b0;
    anim_row    = '0;
    anim_col    = '0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    facing_left = 1'b0;
    hcount      = 10'd100;
    vcount      = 10'd50;
    sprite_x    = 10'd100;
    sprite_y    = 10'd50;
    rom_data    = 12'h0A0;

    // Values held during reset.
    repeat (3) tick;
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_pix",  32'(pix_out), 32'd0);
    check("rst_opq",  32'(pix_opaque), 32'd0);
    check("rst_vld",  32'(pix_out_valid), 32'd0);

    // Release the reset. A hitting request seen at edge 1 is ignored, and the one at edge 2 is taken.
    reset     = 1'b1;
    pix_valid = 1'b1;
    tick;
    tick;
    pix_valid = 1'b0;
    tick;
    check("sync_e1_vld", 32'(pix_out_valid), 32'd0);
    tick;
    check("wait_vld", 32'(pix_out_valid), 32'd1);
    check("wait_opq", 32'(pix_opaque), 32'd0);
    check("wait_pix", 32'(pix_out), 32'd0);
    tick;
    check("wait_vld_end", 32'(pix_out_valid), 32'd0);

    // The frame origin is row 30, col 0; the table exercises the hits, the colour key and the box edges.
    frame(6'd30, 6'd0, 1'b0);
    do_req("hit",      10'd105, 10'd52, 12'h0A0, 14'd4101, 1'b1);
    do_req("key",      10'd105, 10'd52, 12'hF0F, 14'd4101, 1'b0);
    do_req("miss_r",   10'd123, 10'd52, 12'h0A0, 14'd4101, 1'b0);
    do_req("edge_r",   10'd122, 10'd52, 12'h123, 14'd4118, 1'b1);
    do_req("miss_l",   10'd99,  10'd52, 12'h0A0, 14'd4118, 1'b0);
    do_req("miss_b",   10'd105, 10'd80, 12'h0A0, 14'd4118, 1'b0);
    do_req("edge_b",   10'd100, 10'd79, 12'h456, 14'd7552, 1'b1);

    // Facing-left capture with col 23. The expected address depends on whether mirroring is built in.
    frame(6'd30, 6'd23, 1'b1);
    do_req("flip", 10'd100, 10'd50, 12'h0A0, FLIP_ADDR, 1'b1);

    // frame_start arrives in the same cycle as request A. B comes in the following cycle.
    anim_row    = 6'd60;
    anim_col    = 6'd0;
    facing_left = 1'b0;
    frame_start = 1'b1;
    hcount      = 10'd100;
    vcount      = 10'd50;
    pix_valid   = 1'b1;
    tick;
    frame_start = 1'b0;
    tick;
    pix_valid = 1'b0;
    check("fs_same_addr", 32'(rom_addr), 32'(FLIP_ADDR));
    rom_data = 12'h0A0;
    tick;
    check("fs_next_addr", 32'(rom_addr), 32'd7680);
    check("fs_same_opq", 32'(pix_opaque), 32'd1);
    rom_data = 12'h0F0;
    tick;
    check("fs_next_vld", 32'(pix_out_valid), 32'd1);
    check("fs_next_pix", 32'(pix_out), 32'h0F0);
    tick;
    tick;

    // Twenty back-to-back requests. Reset is asserted in the middle of the cycle after the 10th request.
    rom_data = 12'h0A0;
    for (int i = 0; i < 20; i++) begin
      hcount    = 10'(100 + i);
      vcount    = 10'd50;
      pix_valid = 1'b1;
      if (i == 10) begin
        #2 reset = 1'b0;
        #1;
        check("async_vld",  32'(pix_out_valid), 32'd0);
        check("async_opq",  32'(pix_opaque), 32'd0);
        check("async_pix",  32'(pix_out), 32'd0);
        check("async_addr", 32'(rom_addr), 32'd0);
      end
      tick;
      if (i >= 2 && i < 10) begin
        check($sformatf("b2b%0d_vld", i), 32'(pix_out_valid), 32'd1);
        check($sformatf("b2b%0d_opq", i), 32'(pix_opaque), 32'd1);
        check($sformatf("b2b%0d_addr", i), 32'(rom_addr), 32'(7680 + i - 1));
      end
      if (i >= 10)
        check($sformatf("drop%0d_vld", i), 32'(pix_out_valid), 32'd0);
    end
    pix_valid = 1'b0;
    tick;
    reset = 1'b1;
    repeat (3) tick;
    check("post_rst_vld", 32'(pix_out_valid), 32'd0);
    // No frame_start has arrived since the reset, so the FSM is back in WAIT_FRAME and nothing is drawable.
    hcount    = 10'd105;
    vcount    = 10'd52;
    pix_valid = 1'b1;
    tick;
    pix_valid = 1'b0;
    tick;
    tick;
    check("post_rst_req_vld", 32'(pix_out_valid), 32'd1);
    check("post_rst_req_opq", 32'(pix_opaque), 32'd0);
    check("post_rst_req_pix", 32'(pix_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
